// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Opcode constants, FSM state enum, instruction-class enum and
//               ALU operation encodings for the multicycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

   // Major opcodes recognised by the decoder (IR[6:0])
   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LD  = 7'b0000011;
   localparam logic [6:0] OPC_SD  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;

   // ALU operation selects
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CLS_R       = 3'd0,
      CLS_I       = 3'd1,
      CLS_LD      = 3'd2,
      CLS_SD      = 3'd3,
      CLS_BEQ     = 3'd4,
      CLS_ILLEGAL = 3'd5
   } instr_class_e;

   // Map a raw opcode onto its instruction class; anything unknown is illegal
   function automatic instr_class_e decode_class(input logic [6:0] opc);
      instr_class_e cls;
      case (opc)
         OPC_R   : cls = CLS_R;
         OPC_I   : cls = CLS_I;
         OPC_LD  : cls = CLS_LD;
         OPC_SD  : cls = CLS_SD;
         OPC_BEQ : cls = CLS_BEQ;
         default : cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts cycles spent waiting on a memory handshake and flags
//               expiry on the TIMEOUT_CYCLES-th waiting cycle, unless the
//               handshake completes in that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   input  logic done,
   output logic expired
);

   // Count value seen during the final allowed waiting cycle
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: clear wins, otherwise advance while waiting
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable) begin
         count_d = count_q + 8'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // A completion in the final cycle takes precedence over expiry
   assign expired = enable && !done && (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle RISC-V style control FSM (FETCH, DECODE, EXECUTE,
//               MEM, WRITEBACK) with memory-wait timeout and a retired
//               instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        iord,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic        illegal,
   output logic        bus_err,
   output logic [31:0] instr_count
);

   state_e       state_q,  state_d;
   instr_class_e class_q,  class_d;
   logic         run_q,    run_d;
   logic [31:0]  instr_count_q, instr_count_d;

   logic mem_waiting;
   logic timer_clear;
   logic timer_expired;

   // run_q holds all controls low until the first clock edge after reset
   // release, so FETCH only starts driving MemRead from that edge on.
   assign mem_waiting = run_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
   // Clear whenever the wait ends, so every FETCH/MEM entry starts from zero
   assign timer_clear = !mem_waiting || mem_ready || timer_expired;

   mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_mem_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .enable  (mem_waiting),
      .done    (mem_ready),
      .expired (timer_expired)
   );

   // Next-state, class latch, retirement count and control outputs
   always_comb begin
      state_d       = state_q;
      class_d       = class_q;
      run_d         = 1'b1;
      instr_count_d = instr_count_q;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      iord          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      MemtoReg      = 1'b0;
      alu_src       = 1'b0;
      alu_op        = ALU_ADD;
      illegal       = 1'b0;
      bus_err       = 1'b0;

      if (run_q) begin
         case (state_q)
            ST_FETCH: begin
               MemRead = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = ST_DECODE;
               end else if (timer_expired) begin
                  bus_err = 1'b1;
                  state_d = ST_FETCH;
               end
            end

            ST_DECODE: begin
               class_d = decode_class(opcode);
               if (class_d == CLS_ILLEGAL) begin
                  illegal = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_EXECUTE;
               end
            end

            ST_EXECUTE: begin
               case (class_q)
                  CLS_R: begin
                     alu_op  = ALU_FUNCT;
                     state_d = ST_WRITEBACK;
                  end
                  CLS_I: begin
                     alu_src = 1'b1;
                     state_d = ST_WRITEBACK;
                  end
                  CLS_LD, CLS_SD: begin
                     alu_src = 1'b1;
                     state_d = ST_MEM;
                  end
                  CLS_BEQ: begin
                     alu_op        = ALU_SUB;
                     pc_write      = zero;
                     pc_src        = zero;
                     instr_count_d = instr_count_q + 32'd1;
                     state_d       = ST_FETCH;
                  end
                  default: state_d = ST_FETCH;
               endcase
            end

            ST_MEM: begin
               iord     = 1'b1;
               MemRead  = (class_q == CLS_LD);
               MemWrite = (class_q == CLS_SD);
               if (mem_ready) begin
                  if (class_q == CLS_SD) begin
                     instr_count_d = instr_count_q + 32'd1;
                     state_d       = ST_FETCH;
                  end else begin
                     state_d = ST_WRITEBACK;
                  end
               end else if (timer_expired) begin
                  // Abandon the access: no store is committed on a bus error
                  MemWrite = 1'b0;
                  bus_err  = 1'b1;
                  state_d  = ST_FETCH;
               end
            end

            ST_WRITEBACK: begin
               RegWrite      = 1'b1;
               MemtoReg      = (class_q == CLS_LD);
               instr_count_d = instr_count_q + 32'd1;
               state_d       = ST_FETCH;
            end

            default: state_d = ST_FETCH;
         endcase
      end
   end

   // State, class, run flag and retirement counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_FETCH;
         class_q       <= CLS_ILLEGAL;
         run_q         <= 1'b0;
         instr_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         class_q       <= class_d;
         run_q         <= run_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each instruction
//               is walked cycle by cycle with expected controls derived from
//               the instruction class; a counter model tracks retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

   localparam int TO = 15;

   // Bit positions inside the packed control vector
   localparam int B_IRW = 12, B_PCW = 11, B_PCS = 10, B_IORD = 9, B_MR = 8;
   localparam int B_MW = 7, B_RW = 6, B_M2R = 5, B_ASRC = 4, B_ILL = 1, B_BE = 0;

   // Instruction classes as the bench sees them
   localparam int C_R = 0, C_I = 1, C_LD = 2, C_SD = 3, C_BEQ = 4, C_ILL = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        ir_write, pc_write, pc_src, iord, MemRead, MemWrite;
   logic        RegWrite, MemtoReg, alu_src, illegal, bus_err;
   logic [1:0]  alu_op;
   logic [31:0] instr_count;

   logic [12:0] obs;
   logic [31:0] model_count;
   int          errors = 0;
   int          checks = 0;
   logic [6:0]  legal_ops [5];

   assign obs = {ir_write, pc_write, pc_src, iord, MemRead, MemWrite,
                 RegWrite, MemtoReg, alu_src, alu_op, illegal, bus_err};

   multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .iord        (iord),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .RegWrite    (RegWrite),
      .MemtoReg    (MemtoReg),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .illegal     (illegal),
      .bus_err     (bus_err),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   function automatic int cls_of(input logic [6:0] opc);
      case (opc)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LD;
         7'b0100011: return C_SD;
         7'b1100011: return C_BEQ;
         default:    return C_ILL;
      endcase
   endfunction

   task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven
   task automatic step(input logic [12:0] exp, input string tag, input bit retire);
      #1;
      chk({19'd0, obs}, {19'd0, exp}, tag);
      chk(instr_count, model_count, {tag, "_count"});
      @(posedge clk);
      if (retire) model_count = model_count + 32'd1;
      @(negedge clk);
   endtask

   // delay = waiting cycles before mem_ready; delay >= TO forces a timeout
   task automatic do_fetch(input int delay, output bit ok);
      logic [12:0] e;
      ok = 1'b0;
      for (int i = 0; i < TO; i++) begin
         e = '0;
         e[B_MR] = 1'b1;
         if (i < delay) begin
            mem_ready = 1'b0;
            if (i == TO - 1) begin
               e[B_BE] = 1'b1;
               step(e, "fetch_timeout", 1'b0);
               break;
            end
            step(e, "fetch_wait", 1'b0);
         end else begin
            mem_ready = 1'b1;
            e[B_IRW] = 1'b1;
            e[B_PCW] = 1'b1;
            step(e, "fetch_done", 1'b0);
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_instr(input logic [6:0] opc, input logic z,
                            input int fdelay, input int mdelay);
      logic [12:0] e;
      bit          ok;
      int          c;
      do_fetch(fdelay, ok);
      if (!ok) return;
      c = cls_of(opc);
      opcode    = opc;
      mem_ready = 1'($urandom);
      e = '0;
      if (c == C_ILL) begin
         e[B_ILL] = 1'b1;
         step(e, "decode_illegal", 1'b0);
         return;
      end
      step(e, "decode", 1'b0);
      opcode    = 7'($urandom);
      zero      = z;
      mem_ready = 1'($urandom);
      e = '0;
      if (c == C_R) e[3:2] = 2'b10;
      if (c == C_I || c == C_LD || c == C_SD) e[B_ASRC] = 1'b1;
      if (c == C_BEQ) begin
         e[3:2]  = 2'b01;
         e[B_PCW] = z;
         e[B_PCS] = z;
      end
      step(e, "execute", c == C_BEQ);
      if (c == C_BEQ) return;
      if (c == C_LD || c == C_SD) begin
         for (int i = 0; i < TO; i++) begin
            e = '0;
            e[B_IORD] = 1'b1;
            e[B_MR]   = (c == C_LD);
            e[B_MW]   = (c == C_SD);
            if (i < mdelay) begin
               mem_ready = 1'b0;
               if (i == TO - 1) begin
                  e[B_MW] = 1'b0;
                  e[B_BE] = 1'b1;
                  step(e, "mem_timeout", 1'b0);
                  return;
               end
               step(e, "mem_wait", 1'b0);
            end else begin
               mem_ready = 1'b1;
               step(e, "mem_done", c == C_SD);
               break;
            end
         end
         if (c == C_SD) return;
      end
      mem_ready = 1'($urandom);
      e = '0;
      e[B_RW]  = 1'b1;
      e[B_M2R] = (c == C_LD);
      step(e, "writeback", 1'b1);
   endtask

   initial begin
      bit          ok;
      logic [12:0] e;
      int          r;
      int          fd;
      int          md;
      logic [6:0]  op;

      legal_ops[0] = 7'b0110011;
      legal_ops[1] = 7'b0010011;
      legal_ops[2] = 7'b0000011;
      legal_ops[3] = 7'b0100011;
      legal_ops[4] = 7'b1100011;

      rst_n       = 1'b0;
      opcode      = 7'd0;
      zero        = 1'b0;
      mem_ready   = 1'b1;
      model_count = 32'd0;

      // Reset state
      #3;
      chk({19'd0, obs}, 32'd0, "reset_outputs");
      chk(instr_count, 32'd0, "reset_count");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk({19'd0, obs}, 32'd0, "release_before_edge");
      @(posedge clk);
      @(negedge clk);

      // R-type, single-cycle memory
      run_instr(7'b0110011, 1'b0, 0, 0);
      chk(instr_count, 32'd1, "r_retired");
      // LD with three wait cycles in MEM
      run_instr(7'b0000011, 1'b0, 0, 3);
      // BEQ taken and not taken
      run_instr(7'b1100011, 1'b1, 0, 0);
      run_instr(7'b1100011, 1'b0, 0, 0);
      chk(instr_count, 32'd4, "beq_retired");
      // Illegal opcode: no retirement
      run_instr(7'b1111111, 1'b0, 0, 0);
      chk(instr_count, 32'd4, "illegal_no_count");
      // Fetch timeout, then readiness exactly on the last allowed cycle
      do_fetch(TO, ok);
      chk({31'd0, ok}, 32'd0, "fetch_timeout_flag");
      run_instr(7'b0010011, 1'b0, TO - 1, 0);
      // MEM timeout on a store
      run_instr(7'b0100011, 1'b0, 0, TO);
      // LD completing on the last allowed MEM cycle
      run_instr(7'b0000011, 1'b0, 1, TO - 1);

      // Counter wrap through a store
      mem_ready = 1'b0;
      force dut.instr_count_q = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.instr_count_q;
      model_count = 32'hFFFF_FFFF;
      run_instr(7'b0100011, 1'b0, 0, 0);
      chk(instr_count, 32'd0, "count_wrap");

      // Asynchronous reset in the middle of a store's MEM cycle
      do_fetch(0, ok);
      opcode    = 7'b0100011;
      mem_ready = 1'b0;
      step(13'd0, "rst_decode", 1'b0);
      e = '0;
      e[B_ASRC] = 1'b1;
      step(e, "rst_execute", 1'b0);
      mem_ready = 1'b0;
      #1;
      chk({31'd0, MemWrite}, 32'd1, "rst_mem_write_active");
      #2;
      rst_n = 1'b0;
      #1;
      chk({19'd0, obs}, 32'd0, "rst_async_outputs");
      chk(instr_count, 32'd0, "rst_async_count");
      model_count = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk({19'd0, obs}, 32'd0, "rst_release_idle");
      @(posedge clk);
      @(negedge clk);
      run_instr(7'b0110011, 1'b0, 0, 0);

      // Randomised instruction stream
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 6);
         if (r < 5)       op = legal_ops[r];
         else if (r == 5) op = 7'($urandom);
         else             op = 7'b1111111;
         r = $urandom_range(0, 9);
         fd = (r == 0) ? TO : ((r == 1) ? TO - 1 : $urandom_range(0, 2));
         r = $urandom_range(0, 9);
         md = (r == 0) ? TO : ((r == 1) ? TO - 1 : $urandom_range(0, 3));
         run_instr(op, 1'($urandom), fd, md);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
